cache_flush_ctrl: RTL and testbench
===================================

CACHE_FLUSH_CTRL -- requirements
Module: cache_flush_ctrl

Interface
REQ-001: Parameter NUMWAYS, default 4: ways per set, power of 2, at least 2.
REQ-002: Parameter NUMLINES, default 128: sets per cache, power of 2.
REQ-003: Parameter SETLEN, default $clog2(NUMLINES): set-index width.
REQ-004: clk  in  1  sole clock; all state updates on rising edge.
REQ-005: reset  in  1  asynchronous, active-low (asserted at 0); clears all state immediately.
REQ-006: FlushReq  in  1  start a full-cache dirty flush; sampled only in IDLE.
REQ-007: FlushAbort  in  1  stop the flush early; no FlushDone is issued.
REQ-008: DirtyWay  in  NUMWAYS  dirty bits of set FlushAdr; valid in the cycle after FlushAdr is presented.
REQ-009: WBAck  in  1  bus accepted the writeback of the current line.
REQ-010: FlushAdr  out  SETLEN  set index driven to the cache arrays.
REQ-011: FlushWay  out  NUMWAYS  one-hot way under inspection.
REQ-012: WBReq  out  1  request to write back line (FlushAdr, FlushWay).
REQ-013: ClearDirty  out  1  one-cycle strobe; clears the dirty bit of (FlushAdr, FlushWay).
REQ-014: FlushBusy  out  1  high in every state except IDLE.
REQ-015: FlushDone  out  1  one-cycle pulse on normal completion.

Function
REQ-016: FSM states are IDLE, READ, CHECK, WRITEBACK, CLEAR and DONE; encoding is free.
REQ-017: IDLE with FlushReq=1 -> READ, with set counter=0 and way counter=0.
REQ-018: READ lasts exactly 1 cycle (array read latency) -> CHECK.
REQ-019: CHECK, DirtyWay[way]=1 -> WRITEBACK.
REQ-020: CHECK, DirtyWay[way]=0, not the last (set, way) -> advance, then READ.
REQ-021: CHECK, DirtyWay[way]=0, set=NUMLINES-1 and way=NUMWAYS-1 -> DONE.
REQ-022: Advance: way+1; when way wraps from NUMWAYS-1 to 0, set+1.
REQ-023: The set counter never wraps past NUMLINES-1.
REQ-024: WRITEBACK drives WBReq=1 and holds it, FlushAdr and FlushWay stable until the cycle WBAck=1, then -> CLEAR.
REQ-025: WBReq shall never deassert before WBAck is sampled high.
REQ-026: WBAck outside WRITEBACK is ignored.
REQ-027: CLEAR drives ClearDirty=1 for exactly 1 cycle with unchanged FlushAdr/FlushWay.
REQ-028: CLEAR, not the last (set, way) -> advance, then READ.
REQ-029: CLEAR, last (set, way) -> DONE.
REQ-030: DONE drives FlushDone=1 for 1 cycle -> IDLE.
REQ-031: FlushReq in any non-IDLE state is ignored and not queued.
REQ-032: FlushAbort=1 in READ or CHECK -> IDLE next cycle.
REQ-033: FlushAbort=1 in WRITEBACK or CLEAR is latched; the handshake and ClearDirty complete, then -> IDLE instead of advancing or DONE.
REQ-034: FlushAbort in DONE is ignored; FlushDone still pulses.
REQ-035: Aborts never produce FlushDone.
REQ-036: FlushAdr and FlushWay reflect the counters in every state; FlushWay is the decode of the way counter.
REQ-037: Clean-cache flush latency is 2*NUMLINES*NUMWAYS cycles from the FlushReq sample edge to DONE entry.
REQ-038: Each dirty line adds (WBReq-to-WBAck cycles + 1 CLEAR cycle) to the flush latency.

Reset
REQ-039: On reset assertion: state=IDLE, counters=0, pending abort=0, and WBReq, ClearDirty, FlushBusy, FlushDone=0 asynchronously; FlushAdr=0; FlushWay=0...01.
REQ-040: Reset mid-WRITEBACK drops WBReq without waiting for WBAck.
REQ-041: After deassertion the block waits in IDLE for a new FlushReq.

Verification (NUMWAYS=4, NUMLINES=128)
REQ-042: Clean cache: FlushReq sampled at edge t0, DirtyWay=0 -> FlushDone high exactly in cycle t0+1025; WBReq and ClearDirty never high; FlushBusy high for 1025 cycles.
REQ-043: Only set 5, way 2 dirty, WBAck 3 cycles after WBReq rises -> one WBReq with FlushAdr=5 and FlushWay=4'b0100 held 3 cycles; ClearDirty next cycle with same values; FlushDone at t0+1025+4.
REQ-044: FlushAbort pulsed while in CHECK at set 10 -> FlushBusy=0 next cycle; no FlushDone; a new FlushReq restarts at set 0, way 0.
REQ-045: FlushAbort during WRITEBACK at set 20, way 1 -> WBReq held until WBAck, ClearDirty pulses, then IDLE; no FlushDone.
REQ-046: Only set 127, way 3 dirty -> WBReq, then CLEAR, then DONE directly; FlushAdr never exceeds 127.
REQ-047: reset driven to 0 mid-WRITEBACK, between clock edges -> WBReq and FlushBusy fall before the next edge; FlushAdr=0 and FlushWay=4'b0001.

Source files
------------

// File: rtl/cache_flush_ctrl.sv
// Cache flush controller: walks every (set, way) of the cache, writes back
// each dirty line over a request/acknowledge handshake, clears its dirty
// bit, and pulses FlushDone when the whole cache has been visited.
module cache_flush_ctrl #(
    parameter int NUMWAYS  = 4,
    parameter int NUMLINES = 128,
    parameter int SETLEN   = $clog2(NUMLINES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               FlushReq,
    input  logic               FlushAbort,
    input  logic [NUMWAYS-1:0] DirtyWay,
    input  logic               WBAck,
    output logic [SETLEN-1:0]  FlushAdr,
    output logic [NUMWAYS-1:0] FlushWay,
    output logic               WBReq,
    output logic               ClearDirty,
    output logic               FlushBusy,
    output logic               FlushDone
);

    localparam int WAYLEN = $clog2(NUMWAYS);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] READ      = 3'd1;
    localparam logic [2:0] CHECK     = 3'd2;
    localparam logic [2:0] WRITEBACK = 3'd3;
    localparam logic [2:0] CLEAR     = 3'd4;
    localparam logic [2:0] DONE      = 3'd5;

    localparam logic [SETLEN-1:0] LASTSET = SETLEN'(NUMLINES - 1);
    localparam logic [WAYLEN-1:0] LASTWAY = WAYLEN'(NUMWAYS - 1);

    logic [2:0]        state;
    logic [2:0]        nextState;
    logic [SETLEN-1:0] setCnt;
    logic [WAYLEN-1:0] wayCnt;
    logic              abortPend;
    logic              lastLine;
    logic              curDirty;
    logic              abortNow;
    logic              advance;

    assign lastLine = (setCnt == LASTSET) && (wayCnt == LASTWAY);
    assign curDirty = DirtyWay[wayCnt];
    // An abort seen during the handshake is only acted on once CLEAR is done.
    assign abortNow = abortPend || FlushAbort;

    // Step to the next (set, way) only from a line that is finished and not the last.
    assign advance = ((state == CHECK) && !FlushAbort && !curDirty && !lastLine) ||
                     ((state == CLEAR) && !abortNow && !lastLine);

    // Next-state selection.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
        nextState = state;
        case (state)
            IDLE:      if (FlushReq) nextState = READ;
            READ:      nextState = FlushAbort ? IDLE : CHECK;
            CHECK: begin
                if (FlushAbort)    nextState = IDLE;
                else if (curDirty) nextState = WRITEBACK;
                else if (lastLine) nextState = DONE;
                else               nextState = READ;
            end
            WRITEBACK: if (WBAck) nextState = CLEAR;
            CLEAR: begin
                if (abortNow)      nextState = IDLE;
                else if (lastLine) nextState = DONE;
                else               nextState = READ;
            end
            DONE:      nextState = IDLE;
            default:   nextState = IDLE;
        endcase
    end

    // State register; reset forces IDLE so the decoded outputs drop at once.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    // Set/way counters: cleared on a new flush, advanced after each finished line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            setCnt <= '0;
            wayCnt <= '0;
        end else if ((state == IDLE) && FlushReq) begin
            setCnt <= '0;
            wayCnt <= '0;
        end else if (advance) begin
            wayCnt <= wayCnt + 1'b1;
            if (wayCnt == LASTWAY) setCnt <= setCnt + 1'b1;
        end
    end

    // Pending abort: remembered while the writeback handshake finishes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                   abortPend <= 1'b0;
        else if (nextState == IDLE)                   abortPend <= 1'b0;
        else if ((state == WRITEBACK) && FlushAbort)  abortPend <= 1'b1;
    end

    // One-hot decode of the way counter.
    always_comb begin
        FlushWay         = '0;
        FlushWay[wayCnt] = 1'b1;
    end

    assign FlushAdr   = setCnt;
    assign WBReq      = (state == WRITEBACK);
    assign ClearDirty = (state == CLEAR);
    assign FlushBusy  = (state != IDLE);
    assign FlushDone  = (state == DONE);

endmodule

// File: tb/tb_cache_flush_ctrl.sv
// Directed bench for cache_flush_ctrl (NUMWAYS=4, NUMLINES=128): clean flush,
// single dirty lines, aborts in CHECK/READ/WRITEBACK and reset mid-writeback.
module tb_cache_flush_ctrl;

    localparam int NUMWAYS  = 4;
    localparam int NUMLINES = 128;
    localparam int SETLEN   = 7;

    logic              clk = 1'b0;
    logic              reset;
    logic              FlushReq;
    logic              FlushAbort;
    logic [NUMWAYS-1:0] DirtyWay;
    logic              WBAck;
    logic [SETLEN-1:0] FlushAdr;
    logic [NUMWAYS-1:0] FlushWay;
    logic              WBReq;
    logic              ClearDirty;
    logic              FlushBusy;
    logic              FlushDone;

    logic [NUMWAYS-1:0] dirtyMem [NUMLINES];

    int errors = 0;
    int checks = 0;

    // Bus responder and activity monitor state (written only by the monitor).
    int ackDelay = 3;
    int wbCnt = 0;
    int wbRises = 0, wbCycles = 0, wbUnstable = 0;
    int clrCnt = 0, doneCnt = 0, busyCnt = 0, maxAdr = 0;
    logic wbPrev = 1'b0;
    logic [SETLEN-1:0]  wbAdr = '0, clrAdr = '0;
    logic [NUMWAYS-1:0] wbWay = '0, clrWay = '0;

    cache_flush_ctrl #(.NUMWAYS(NUMWAYS), .NUMLINES(NUMLINES)) dut (
        .clk(clk), .reset(reset), .FlushReq(FlushReq), .FlushAbort(FlushAbort),
        .DirtyWay(DirtyWay), .WBAck(WBAck), .FlushAdr(FlushAdr), .FlushWay(FlushWay),
        .WBReq(WBReq), .ClearDirty(ClearDirty), .FlushBusy(FlushBusy), .FlushDone(FlushDone)
    );

    always #5 clk = ~clk;

    // Cache dirty array seen through the current set index.
    assign DirtyWay = dirtyMem[FlushAdr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clearDirtyMem();
        for (int i = 0; i < NUMLINES; i++) dirtyMem[i] = '0;
    endtask

    // Start a flush; returns after the sampling edge t0 with FlushReq low again.
    task automatic startFlush();
        FlushReq = 1'b1;
        step();
        FlushReq = 1'b0;
    endtask

    // Counts edges after t0 until FlushDone is seen; -1 on timeout.
    task automatic waitDone(output int edges);
        edges = -1;
        for (int k = 1; k <= 3000; k++) begin
            step();
            if (FlushDone) begin
                edges = k;
                break;
            end
        end
    endtask

    // Monitor and WBAck responder, sampling on the falling edge.
    initial begin
        WBAck = 1'b0;
        forever begin
            @(negedge clk);
            if (WBReq) begin
                if (!wbPrev) begin
                    wbRises++;
                    wbAdr = FlushAdr;
                    wbWay = FlushWay;
                    wbCnt = 0;
                end
                wbCnt++;
                wbCycles++;
                if (FlushAdr != wbAdr || FlushWay != wbWay) wbUnstable++;
            end else begin
                wbCnt = 0;
            end
            WBAck = WBReq && (wbCnt == ackDelay);
            wbPrev = WBReq;
            if (ClearDirty) begin
                clrCnt++;
                clrAdr = FlushAdr;
                clrWay = FlushWay;
            end
            if (FlushDone) doneCnt++;
            if (FlushBusy) busyCnt++;
            if (int'(FlushAdr) > maxAdr) maxAdr = int'(FlushAdr);
        end
    end

    initial begin
        int edges, busy0, wb0, wbc0, clr0, done0;
        bit found;
        reset = 1'b0;
        FlushReq = 1'b0;
        FlushAbort = 1'b0;
        clearDirtyMem();
        #12;
        check("rst_wbreq", WBReq, 0);
        check("rst_clear", ClearDirty, 0);
        check("rst_busy", FlushBusy, 0);
        check("rst_done", FlushDone, 0);
        check("rst_adr", FlushAdr, 0);
        check("rst_way", FlushWay, 4'b0001);
        step();
        reset = 1'b1;
        step();
        step();
        check("idle_busy", FlushBusy, 0);

        // Clean cache.
        busy0 = busyCnt; wb0 = wbRises; clr0 = clrCnt; done0 = doneCnt;
        startFlush();
        check("start_adr", FlushAdr, 0);
        check("start_way", FlushWay, 4'b0001);
        check("start_busy", FlushBusy, 1);
        waitDone(edges);
        check("clean_latency", edges, 1024);
        step();
        check("clean_busy_cycles", busyCnt - busy0, 1025);
        check("clean_idle", FlushBusy, 0);
        check("clean_wbreq", wbRises - wb0, 0);
        check("clean_clear", clrCnt - clr0, 0);
        check("clean_done", doneCnt - done0, 1);

        // Set 5, way 2 dirty, ack three cycles after WBReq rises.
        dirtyMem[5] = 4'b0100;
        busy0 = busyCnt; wb0 = wbRises; wbc0 = wbCycles; clr0 = clrCnt; done0 = doneCnt;
        startFlush();
        waitDone(edges);
        check("d5_latency", edges, 1028);
        step();
        check("d5_busy_cycles", busyCnt - busy0, 1029);
        check("d5_wb_count", wbRises - wb0, 1);
        check("d5_wb_cycles", wbCycles - wbc0, 3);
        check("d5_wb_adr", wbAdr, 5);
        check("d5_wb_way", wbWay, 4'b0100);
        check("d5_wb_stable", wbUnstable, 0);
        check("d5_clr_count", clrCnt - clr0, 1);
        check("d5_clr_adr", clrAdr, 5);
        check("d5_clr_way", clrWay, 4'b0100);
        check("d5_done", doneCnt - done0, 1);
        clearDirtyMem();

        // Abort while in CHECK at set 10.
        done0 = doneCnt;
        startFlush();
        found = 0;
        for (int k = 0; k < 200; k++) begin
            if (FlushAdr == 10) begin found = 1; break; end
            step();
        end
        check("ab10_reached", found, 1);
        step();
        FlushAbort = 1'b1;
        step();
        FlushAbort = 1'b0;
        check("ab10_busy", FlushBusy, 0);
        repeat (20) step();
        check("ab10_no_done", doneCnt - done0, 0);
        check("ab10_stay_idle", FlushBusy, 0);
        startFlush();
        check("restart_adr", FlushAdr, 0);
        check("restart_way", FlushWay, 4'b0001);
        FlushAbort = 1'b1;
        step();
        FlushAbort = 1'b0;
        check("abread_busy", FlushBusy, 0);
        FlushReq = 1'b1;
        step();
        FlushReq = 1'b0;
        check("abread_restart_adr", FlushAdr, 0);
        FlushAbort = 1'b1;
        step();
        FlushAbort = 1'b0;

        // Abort during WRITEBACK at set 20, way 1.
        dirtyMem[20] = 4'b0010;
        wbc0 = wbCycles; clr0 = clrCnt; done0 = doneCnt;
        startFlush();
        found = 0;
        for (int k = 0; k < 2000; k++) begin
            if (WBReq) begin found = 1; break; end
            step();
        end
        check("ab20_wb_seen", found, 1);
        check("ab20_wb_adr", FlushAdr, 20);
        check("ab20_wb_way", FlushWay, 4'b0010);
        FlushAbort = 1'b1;
        step();
        FlushAbort = 1'b0;
        check("ab20_wb_held", WBReq, 1);
        found = 0;
        for (int k = 0; k < 50; k++) begin
            if (!FlushBusy) begin found = 1; break; end
            step();
        end
        check("ab20_to_idle", found, 1);
        check("ab20_wb_cycles", wbCycles - wbc0, 3);
        check("ab20_clr_count", clrCnt - clr0, 1);
        check("ab20_clr_adr", clrAdr, 20);
        check("ab20_clr_way", clrWay, 4'b0010);
        repeat (5) step();
        check("ab20_no_done", doneCnt - done0, 0);
        clearDirtyMem();

        // Set 127, way 3 dirty: CLEAR goes straight to DONE.
        dirtyMem[127] = 4'b1000;
        clr0 = clrCnt; done0 = doneCnt;
        startFlush();
        waitDone(edges);
        check("d127_latency", edges, 1028);
        check("d127_clr_adr", clrAdr, 127);
        check("d127_clr_way", clrWay, 4'b1000);
        check("d127_clr_count", clrCnt - clr0, 1);
        step();
        check("d127_done", doneCnt - done0, 1);
        check("d127_max_adr", maxAdr, 127);
        check("d127_idle", FlushBusy, 0);
        clearDirtyMem();

        // Reset mid-WRITEBACK with an ack that never arrives in time.
        dirtyMem[3] = 4'b0001;
        ackDelay = 100;
        startFlush();
        found = 0;
        for (int k = 0; k < 200; k++) begin
            if (WBReq) begin found = 1; break; end
            step();
        end
        check("rwb_wb_seen", found, 1);
        step();
        #1 reset = 1'b0;
        #1;
        check("rwb_wbreq", WBReq, 0);
        check("rwb_busy", FlushBusy, 0);
        check("rwb_adr", FlushAdr, 0);
        check("rwb_way", FlushWay, 4'b0001);
        step();
        reset = 1'b1;
        ackDelay = 3;
        repeat (5) step();
        check("rwb_wait_idle", FlushBusy, 0);
        check("rwb_no_wb", WBReq, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
